// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with tick strobes and 50% duty divided clocks.
// New divisors sit in a shadow register and are only adopted at wrap, disable or sync, so reprogramming never glitches.
module clk_div_bank #(
    parameter int             NCH     = 4,
    parameter int             W       = 32,
    parameter logic [W-1:0]   DEF_DIV = 32'd49_999_999,
    localparam int            CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CCLK,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [W-1:0]     wr_div,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] cnt_reg;
            logic [W-1:0] active_reg;
            logic [W-1:0] shadow_reg;
            logic         clk_reg;
            logic         tick_reg;
            logic         wr_hit;

            // Out-of-range channel indices never match any generated channel.
            assign wr_hit = wr_en && (wr_ch == CHW'(gi));

            always_ff @(posedge CCLK or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    active_reg <= DEF_DIV;
                    shadow_reg <= DEF_DIV;
                    clk_reg    <= 1'b0;
                    tick_reg   <= 1'b0;
                end else begin
                    if (wr_hit)
                        shadow_reg <= wr_div;
                    // Every reload uses the pre-edge shadow, so a write on a wrap edge waits one period.
                    if (sync || !en[gi]) begin
                        cnt_reg    <= '0;
                        clk_reg    <= 1'b0;
                        tick_reg   <= 1'b0;
                        active_reg <= shadow_reg;
                    end else if (cnt_reg == active_reg) begin
                        cnt_reg    <= '0;
                        clk_reg    <= ~clk_reg;
                        tick_reg   <= 1'b1;
                        active_reg <= shadow_reg;
                    end else begin
                        cnt_reg    <= cnt_reg + 1'b1;
                        tick_reg   <= 1'b0;
                    end
                end
            end

            assign clk_out[gi] = clk_reg;
            assign tick[gi]    = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized and directed bench for clk_div_bank against a countdown-based behavioural model.
// NCH=3 leaves wr_ch=3 as an out-of-range index; W=8 makes the all-ones divisor cheap to exercise.
module tb_clk_div_bank;
    localparam int           NCH     = 3;
    localparam int           W       = 8;
    localparam int           CHW     = 2;
    localparam logic [W-1:0] DEF_DIV = 8'd9;

    logic             CCLK = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   en;
    logic             sync;
    logic             wr_en;
    logic [CHW-1:0]   wr_ch;
    logic [W-1:0]     wr_div;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    clk_div_bank #(.NCH(NCH), .W(W), .DEF_DIV(DEF_DIV)) dut (
        .CCLK(CCLK), .rst_n(rst_n), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 CCLK = ~CCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: each channel counts down the enabled edges left before its next tick.
    logic [W-1:0] m_shadow [NCH];
    logic [W-1:0] m_left   [NCH];
    logic         m_clk    [NCH];
    logic         m_tick   [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_shadow[c] = DEF_DIV;
            m_left[c]   = DEF_DIV;
            m_clk[c]    = 1'b0;
            m_tick[c]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            logic [W-1:0] sh_old;
            sh_old = m_shadow[c];
            if (wr_en && int'(wr_ch) == c)
                m_shadow[c] = wr_div;
            if (sync || !en[c]) begin
                m_left[c] = sh_old;
                m_clk[c]  = 1'b0;
                m_tick[c] = 1'b0;
            end else if (m_left[c] == 0) begin
                m_left[c] = sh_old;
                m_clk[c]  = ~m_clk[c];
                m_tick[c] = 1'b1;
            end else begin
                m_left[c] = m_left[c] - 1'b1;
                m_tick[c] = 1'b0;
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [NCH-1:0] exp_clk, exp_tick;
        for (int c = 0; c < NCH; c++) begin
            exp_clk[c]  = m_clk[c];
            exp_tick[c] = m_tick[c];
        end
        check({tag, ".tick"},    32'(tick),    32'(exp_tick));
        check({tag, ".clk_out"}, 32'(clk_out), 32'(exp_clk));
    endtask

    string phase = "init";

    task automatic step();
        @(posedge CCLK);
        model_edge();
        @(negedge CCLK);
        compare(phase);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int ch, input int d);
        wr_en  = 1'b1;
        wr_ch  = CHW'(ch);
        wr_div = W'(d);
        $display("[TB] %s: write ch=%0d div=%0d", phase, ch, d);
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = '1; sync = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        model_reset();

        // Reset holds outputs low even with every channel enabled.
        phase = "reset";
        repeat (3) @(negedge CCLK);
        compare(phase);
        en = '0;
        rst_n = 1'b1;

        phase = "setup";
        wr(0, 3); wr(1, 5); wr(2, 0);
        step();

        phase = "basic";
        en = 3'b011;
        run(30);

        phase = "reprogram";
        run(2);
        wr(1, 1);
        run(20);

        // Write ch0 on the edge where it wraps.
        phase = "same_edge";
        begin
            int guard = 0;
            while (m_left[0] != 0 && guard < 50) begin step(); guard++; end
            check("same_edge.wrap_found", 32'(guard < 50), 32'd1);
        end
        wr(0, 2);
        run(20);

        phase = "sync";
        wr(1, 4);
        run(13);
        sync = 1'b1; step(); sync = 1'b0;
        run(15);

        phase = "d_zero";
        en = 3'b111;
        run(10);

        phase = "bad_ch";
        wr(3, 7);
        en = '0; step(); en = '1;
        run(20);

        phase = "d_max";
        wr(2, 255);
        en[2] = 1'b0; step(); en[2] = 1'b1;
        run(600);

        phase = "en_drop";
        run(3);
        en[0] = 1'b0; step(); step(); en[0] = 1'b1;
        run(10);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        phase = "async_rst";
        @(posedge CCLK);
        model_edge();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare(phase);
        @(negedge CCLK);
        compare(phase);
        rst_n = 1'b1;

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++)
                en[c] = ($urandom_range(0, 15) != 0);
            sync = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 9) == 0) begin
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
            end else begin
                step();
            end
        end
        sync = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
